// File: rtl/b8_mul_pkg.sv
// Shared opcode/funct encodings and FSM state type for the way0 multiply unit.
package b8_mul_pkg;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OP32  = 7'b0111011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
endpackage

// File: rtl/ex_mul_way0_if.sv
// Decode->execute payload handshake plus the writeback result handshake.
interface ex_mul_way0_if #(parameter int XLEN = 64);
    logic            valid_i;
    logic            ready_o;
    logic [4:0]      rdAddr_i;
    logic            rdWriteEnable_i;
    logic [6:0]      opCode_i;
    logic [2:0]      funct3_i;
    logic [6:0]      funct7_i;
    logic [XLEN-1:0] rs1ReadData_i;
    logic [XLEN-1:0] rs2ReadData_i;
    logic            flush_i;
    logic            valid_o;
    logic            ready_i;
    logic [4:0]      rdAddr_o;
    logic            rdWriteEnable_o;
    logic [XLEN-1:0] result_o;

    modport slave (
        input  valid_i, rdAddr_i, rdWriteEnable_i, opCode_i, funct3_i, funct7_i,
               rs1ReadData_i, rs2ReadData_i, flush_i, ready_i,
        output ready_o, valid_o, rdAddr_o, rdWriteEnable_o, result_o
    );

    modport master (
        output valid_i, rdAddr_i, rdWriteEnable_i, opCode_i, funct3_i, funct7_i,
               rs1ReadData_i, rs2ReadData_i, flush_i, ready_i,
        input  ready_o, valid_o, rdAddr_o, rdWriteEnable_o, result_o
    );
endinterface

// File: rtl/mul_step.sv
// Combinational shift-add slice: folds STEP multiplier bits into the accumulator.
module mul_step #(
    parameter int W    = 128,
    parameter int STEP = 2
) (
    input  logic [W-1:0]    acc_i,
    input  logic [W-1:0]    mcand_i,
    input  logic [STEP-1:0] bits_i,
    output logic [W-1:0]    acc_o
);
    logic [STEP:0][W-1:0] part;

    assign part[0] = acc_i;
    for (genvar k = 0; k < STEP; k++) begin : g_bit
        assign part[k+1] = part[k] + (bits_i[k] ? (mcand_i << k) : '0);
    end
    assign acc_o = part[STEP];
endmodule

// File: rtl/ex_mul_way0.sv
// Iterative RV64M multiplier on the way0 execute port: magnitude shift-add,
// sign fixup and result select folded into the final CALC cycle.
module ex_mul_way0
    import b8_mul_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int STEP = 2
) (
    input logic         clk,
    input logic         reset,
    ex_mul_way0_if.slave bus
);
    localparam int ITERS   = XLEN / STEP;
    localparam int ITERS_W = 32 / STEP;
    localparam int CW      = $clog2(ITERS + 1);
    localparam int PW      = 2 * XLEN;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   acc_q, acc_d, mcand_q, mcand_d, acc_step, prod;
    logic [XLEN-1:0] mplier_q, mplier_d, res_q, res_d;
    logic            neg_q, neg_d, is_w_q, is_w_d, we_q, we_d, valid_q, valid_d;
    logic [2:0]      f3_q, f3_d;
    logic [4:0]      rd_q, rd_d;

    logic            is_w, is_mul, sgn1, sgn2, neg1, neg2;
    logic [XLEN-1:0] op1, op2, mag1, mag2;

    // Operands are reduced to magnitudes up front; the sign is restored once at the end.
    always_comb begin
        is_w   = bus.opCode_i == OPC_OP32;
        is_mul = (bus.funct7_i == F7_MULDIV) &&
                 (((bus.opCode_i == OPC_OP) && !bus.funct3_i[2]) ||
                  (is_w && (bus.funct3_i == F3_MUL)));
        sgn1   = is_w || (bus.funct3_i != F3_MULHU);
        sgn2   = is_w || (bus.funct3_i == F3_MUL) || (bus.funct3_i == F3_MULH);
        op1    = is_w ? {{(XLEN-32){bus.rs1ReadData_i[31]}}, bus.rs1ReadData_i[31:0]}
                      : bus.rs1ReadData_i;
        op2    = is_w ? {{(XLEN-32){bus.rs2ReadData_i[31]}}, bus.rs2ReadData_i[31:0]}
                      : bus.rs2ReadData_i;
        neg1   = sgn1 && op1[XLEN-1];
        neg2   = sgn2 && op2[XLEN-1];
        mag1   = neg1 ? -op1 : op1;
        mag2   = neg2 ? -op2 : op2;
    end

    mul_step #(.W(PW), .STEP(STEP)) u_step (
        .acc_i  (acc_q),
        .mcand_i(mcand_q),
        .bits_i (mplier_q[STEP-1:0]),
        .acc_o  (acc_step)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        is_w_d   = is_w_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        we_d     = we_q;
        valid_d  = valid_q;
        res_d    = res_q;
        prod     = neg_q ? -acc_step : acc_step;
        case (state_q)
            IDLE: if (bus.valid_i && !bus.flush_i) begin
                rd_d     = bus.rdAddr_i;
                we_d     = bus.rdWriteEnable_i && is_mul;
                f3_d     = bus.funct3_i;
                is_w_d   = is_w;
                neg_d    = neg1 ^ neg2;
                acc_d    = '0;
                mcand_d  = {{XLEN{1'b0}}, mag1};
                mplier_d = mag2;
                cnt_d    = is_w ? CW'(ITERS_W) : CW'(ITERS);
                if (is_mul) begin
                    state_d = CALC;
                end else begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    res_d   = '0;
                end
            end
            CALC: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << STEP;
                mplier_d = mplier_q >> STEP;
                cnt_d    = cnt_q - CW'(1);
                // Last slice: the fixed-up product goes straight to the result register.
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    if (is_w_q)
                        res_d = {{(XLEN-32){prod[31]}}, prod[31:0]};
                    else if (f3_q == F3_MUL)
                        res_d = prod[XLEN-1:0];
                    else
                        res_d = prod[PW-1:XLEN];
                end
            end
            DONE: if (bus.ready_i) begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush_i) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            is_w_q   <= 1'b0;
            f3_q     <= '0;
            rd_q     <= '0;
            we_q     <= 1'b0;
            valid_q  <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            is_w_q   <= is_w_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            we_q     <= we_d;
            valid_q  <= valid_d;
            res_q    <= res_d;
        end
    end

    assign bus.ready_o         = state_q == IDLE;
    assign bus.valid_o         = valid_q;
    assign bus.rdAddr_o        = rd_q;
    assign bus.rdWriteEnable_o = we_q;
    assign bus.result_o        = res_q;
endmodule
